// File: rtl/debounce_edge_detect_if.sv
// Signal bundle between a raw input source and the debounce/edge-detect stage.
// The master drives the raw level and enable; the slave returns the conditioned outputs.
interface debounce_edge_detect_if;
   logic d;
   logic en;
   logic q_db;
   logic rise;
   logic fall;
   logic busy;

   modport master (
      output d,
      output en,
      input  q_db,
      input  rise,
      input  fall,
      input  busy
   );

   modport slave (
      input  d,
      input  en,
      output q_db,
      output rise,
      output fall,
      output busy
   );
endinterface

// File: rtl/debounce_edge_detect.sv
// Synchronises a raw asynchronous level, filters it with a stable-count FSM, and emits a
// clean registered level plus single-cycle rise/fall pulses.
//
//   state      | meaning
//   ST_LOW     | committed level 0, input agrees
//   ST_RISING  | committed level 0, counting consecutive 1 samples
//   ST_HIGH    | committed level 1, input agrees
//   ST_FALLING | committed level 1, counting consecutive 0 samples
module debounce_edge_detect #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input logic                   clk,
   input logic                   rst,
   debounce_edge_detect_if.slave db
);

   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_RISING  = 2'd1,
      ST_HIGH    = 2'd2,
      ST_FALLING = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   d_s;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   q_db_q, q_db_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // The synchroniser runs every cycle so the enable never leaves metastable samples behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], db.d};
      end
   end

   assign d_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         q_db_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_db_q  <= q_db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_db_d  = q_db_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (db.en) begin
         case (state_q)
            ST_LOW: begin
               if (d_s) begin
                  if (STABLE_CYCLES == 1) begin
                     state_d = ST_HIGH;
                     q_db_d  = 1'b1;
                     rise_d  = 1'b1;
                  end else begin
                     state_d = ST_RISING;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            ST_RISING: begin
               if (!d_s) begin
                  state_d = ST_LOW;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_HIGH;
                  cnt_d   = '0;
                  q_db_d  = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (!d_s) begin
                  if (STABLE_CYCLES == 1) begin
                     state_d = ST_LOW;
                     q_db_d  = 1'b0;
                     fall_d  = 1'b1;
                  end else begin
                     state_d = ST_FALLING;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            ST_FALLING: begin
               if (d_s) begin
                  state_d = ST_HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_LOW;
                  cnt_d   = '0;
                  q_db_d  = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign db.q_db = q_db_q;
   assign db.rise = rise_q;
   assign db.fall = fall_q;
   assign db.busy = (state_q == ST_RISING) || (state_q == ST_FALLING);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect: pulse events go through an expected-event queue
// checked by a monitor; level outputs are checked at hand-computed times.
module tb_debounce_edge_detect;

   logic clk;
   logic rst;
   logic rst1;

   debounce_edge_detect_if ifa ();
   debounce_edge_detect_if ifb ();

   debounce_edge_detect dut_a (
      .clk (clk),
      .rst (rst),
      .db  (ifa.slave)
   );

   debounce_edge_detect #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (1),
      .CNT_W         (1)
   ) dut_b (
      .clk (clk),
      .rst (rst1),
      .db  (ifb.slave)
   );

   typedef struct {
      bit     is_rise;
      longint t_edge;
   } ev_t;

   ev_t exp_q[$];
   ev_t ev_m;
   int  n_checks = 0;
   int  n_fail   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic wait_until(input longint t);
      if (t > longint'($time)) #(t - longint'($time));
   endtask

   task automatic push_ev(input bit is_rise, input longint t_edge);
      ev_t e;
      e.is_rise = is_rise;
      e.t_edge  = t_edge;
      exp_q.push_back(e);
   endtask

   // Every rise/fall pulse seen on DUT A must match the head of the expected queue.
   always @(negedge clk) begin
      if (ifa.rise === 1'b1 || ifa.fall === 1'b1) begin
         n_checks++;
         if (ifa.rise === 1'b1 && ifa.fall === 1'b1) begin
            n_fail++;
            $display("FAIL pulse_both t=%0t: rise and fall both high", $time);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_unexpected t=%0t: got rise=%b fall=%b, expected none",
                     $time, ifa.rise, ifa.fall);
         end else begin
            ev_m = exp_q.pop_front();
            if (ev_m.is_rise != ifa.rise || ev_m.t_edge != longint'($time) - 5) begin
               n_fail++;
               $display("FAIL pulse_match t=%0t: got rise=%b at edge %0d, expected rise=%b at edge %0d",
                        $time, ifa.rise, longint'($time) - 5, ev_m.is_rise, ev_m.t_edge);
            end
         end
      end
   end

   initial begin
      rst     = 1'b1;
      rst1    = 1'b1;
      ifa.d   = 1'b1;
      ifa.en  = 1'b1;
      ifb.d   = 1'b0;
      ifb.en  = 1'b1;

      // reset state and first rise
      wait_until(1);
      check("rst_q_db", ifa.q_db, 1'b0);
      check("rst_rise", ifa.rise, 1'b0);
      check("rst_fall", ifa.fall, 1'b0);
      check("rst_busy", ifa.busy, 1'b0);
      check("rst_b_q_db", ifb.q_db, 1'b0);
      push_ev(1'b1, 65);
      wait_until(12);
      rst  = 1'b0;
      rst1 = 1'b0;
      wait_until(30);  check("t1_busy_pre", ifa.busy, 1'b0);
      wait_until(40);  check("t1_busy", ifa.busy, 1'b1);
                       check("t1_q_db_early", ifa.q_db, 1'b0);
      wait_until(60);  check("t1_q_db_pre", ifa.q_db, 1'b0);
      wait_until(70);  check("t1_q_db", ifa.q_db, 1'b1);
      wait_until(80);  check("t1_rise_off", ifa.rise, 1'b0);
                       check("t1_busy_off", ifa.busy, 1'b0);
                       check("t1_q_db_hold", ifa.q_db, 1'b1);

      // high to low commit
      wait_until(100); ifa.d = 1'b0;
      push_ev(1'b0, 155);
      wait_until(150); check("t3_q_db_pre", ifa.q_db, 1'b1);
                       check("t3_busy", ifa.busy, 1'b1);
      wait_until(160); check("t3_q_db", ifa.q_db, 1'b0);
      wait_until(170); check("t3_fall_off", ifa.fall, 1'b0);

      // short glitch rejected
      wait_until(180); ifa.d = 1'b1;
      wait_until(200); ifa.d = 1'b0;
      wait_until(210); check("t2_busy", ifa.busy, 1'b1);
      wait_until(230); check("t2_busy_off", ifa.busy, 1'b0);
                       check("t2_q_db", ifa.q_db, 1'b0);

      // input toggling every cycle
      for (int i = 0; i < 10; i++) begin
         wait_until(260 + 10 * i);
         ifa.d = (i % 2 == 0) ? 1'b1 : 1'b0;
      end
      wait_until(360); check("tog_q_db", ifa.q_db, 1'b0);
      wait_until(390); check("tog_busy_off", ifa.busy, 1'b0);

      // reset in RISING with cnt=2
      wait_until(400); ifa.d = 1'b1;
      wait_until(430); check("t4_busy_pre", ifa.busy, 1'b1);
      wait_until(437); rst = 1'b1;
      wait_until(440); check("t4_q_db", ifa.q_db, 1'b0);
                       check("t4_busy", ifa.busy, 1'b0);
                       check("t4_rise", ifa.rise, 1'b0);
                       check("t4_fall", ifa.fall, 1'b0);
      wait_until(452); rst = 1'b0;
      push_ev(1'b1, 505);
      wait_until(500); check("t4_requal_pre", ifa.q_db, 1'b0);
      wait_until(510); check("t4_requal", ifa.q_db, 1'b1);

      // reset in FALLING while q_db=1: drops at once, no fall pulse
      wait_until(520); ifa.d = 1'b0;
      wait_until(550); check("t4f_busy_pre", ifa.busy, 1'b1);
                       check("t4f_q_db_pre", ifa.q_db, 1'b1);
      wait_until(558); rst = 1'b1;
      wait_until(560); check("t4f_q_db", ifa.q_db, 1'b0);
                       check("t4f_busy", ifa.busy, 1'b0);
      wait_until(572); rst = 1'b0;

      // enable gating
      wait_until(580); ifa.en = 1'b0; ifa.d = 1'b1;
      wait_until(690); check("t5_q_db_dis", ifa.q_db, 1'b0);
                       check("t5_busy_dis", ifa.busy, 1'b0);
      wait_until(692); ifa.en = 1'b1;
      push_ev(1'b1, 725);
      wait_until(700); check("t5_busy_en", ifa.busy, 1'b1);
      wait_until(720); check("t5_q_db_pre", ifa.q_db, 1'b0);
      wait_until(730); check("t5_q_db", ifa.q_db, 1'b1);

      // enable dropped mid-count holds the count
      wait_until(740); ifa.d = 1'b0;
      push_ev(1'b0, 825);
      wait_until(778); ifa.en = 1'b0;
      wait_until(800); check("hold_busy", ifa.busy, 1'b1);
                       check("hold_q_db", ifa.q_db, 1'b1);
      wait_until(808); ifa.en = 1'b1;
      wait_until(820); check("hold_q_db_pre", ifa.q_db, 1'b1);
      wait_until(830); check("hold_q_db_post", ifa.q_db, 1'b0);

      // STABLE_CYCLES=1 instance follows d two edges after sampling
      wait_until(850); ifb.d = 1'b1;
      wait_until(870); check("t6_q_db_pre", ifb.q_db, 1'b0);
      wait_until(880); check("t6_q_db", ifb.q_db, 1'b1);
                       check("t6_rise", ifb.rise, 1'b1);
                       check("t6_busy", ifb.busy, 1'b0);
      wait_until(890); check("t6_rise_off", ifb.rise, 1'b0);
      wait_until(900); ifb.d = 1'b0;
      wait_until(920); check("t6_q_db_hold", ifb.q_db, 1'b1);
      wait_until(930); check("t6_q_db_fall", ifb.q_db, 1'b0);
                       check("t6_fall", ifb.fall, 1'b1);
      wait_until(940); check("t6_fall_off", ifb.fall, 1'b0);
      wait_until(950); ifb.d = 1'b1;
      wait_until(960); ifb.d = 1'b0;
      wait_until(970); check("t6g_q_db_pre", ifb.q_db, 1'b0);
      wait_until(980); check("t6g_q_db_hi", ifb.q_db, 1'b1);
                       check("t6g_rise", ifb.rise, 1'b1);
      wait_until(990); check("t6g_q_db_lo", ifb.q_db, 1'b0);
                       check("t6g_fall", ifb.fall, 1'b1);
                       check("t6g_rise_off", ifb.rise, 1'b0);

      wait_until(1000);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pulses_missing: got %0d pulses outstanding, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
